sort8_ctrl: RTL and testbench
=============================

Name: sort8_ctrl

Overview:
- Sequencer that time-shares one 8-bit magnitude comparator (`gte = A>=B`) to sort a block of N unsigned bytes in ascending order.
- Accepts N bytes on a valid/ready input stream, then bubble-sorts them in place (one compare per cycle), then streams them out on a valid/ready output.
- Sits between a byte producer and consumer in the datapath; the comparator is the only magnitude-compare resource.

Parameters:
- N, 8, number of bytes per block; legal range 2..16.
- W, 8, data width; fixed to 8 to match the comparator.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a byte.
- in_data  input  8  unsigned input byte.
- in_ready  output  1  block accepts a byte this cycle.
- out_valid  output  1  out_data holds a sorted byte.
- out_data  output  8  sorted byte, smallest first.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in SORT or OUT.
- done  output  1  one-cycle pulse after the last byte of a block is accepted.

Behaviour:
- Storage: mem[0..N-1] of 8 bits; counters wr_idx, rd_idx, idx, pass ($clog2(N) bits); flag swapped.
- rst_n low (async): state=LOAD; mem, counters, swapped cleared.
- Output values during reset: out_valid=0, out_data=0, busy=0, done=0, in_ready=0.
- in_ready is 1 from the first cycle after reset release.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: mem[wr_idx]<=in_data; wr_idx++.
  - On the N-th accept: wr_idx<=0, idx<=0, pass<=0, swapped<=0; next state SORT.
- SORT:
  - in_ready=0, busy=1.
  - Comparator driven A=mem[idx+1], B=mem[idx].
  - If gte==0 (strictly out of order): swap mem[idx] and mem[idx+1] in the same cycle; swapped<=1.
  - Equal values are never swapped, so the sort is stable.
  - If idx < N-2-pass: idx++.
  - Else (end of pass):
    - If pass==N-2, or no swap occurred this pass (including the current cycle): enter OUT, rd_idx<=0.
    - Otherwise: pass++, idx<=0, swapped<=0.
  - Sort latency is N-1 cycles for already-sorted input and N(N-1)/2 cycles worst case (7 and 28 for N=8).
- OUT:
  - out_valid=1, out_data=mem[rd_idx], busy=1.
  - out_data must hold stable while out_valid && !out_ready.
  - On handshake: rd_idx++.
  - On the N-th handshake: state=LOAD, rd_idx<=0; done=1 in the following cycle only.
  - in_ready returns to 1 in that same following cycle.
- out_data=0 whenever out_valid=0.
- in_valid outside LOAD is ignored; no data is lost because in_ready=0.
- out_ready outside OUT is ignored.
- Reset mid-SORT or mid-OUT aborts the block: the partial block is discarded and no done pulse is generated.
- Back-to-back blocks: the first byte of block k+1 can be accepted in the cycle done pulses for block k.

Decomposition:
- Shared package sort_pkg:
  - state typedef {LOAD, SORT, OUT}.
  - Constants DATA_W=8 and default N=8.
- One sub-module instance: comparator (8-bit, gte=A>=B), driven from the mem[idx]/mem[idx+1] read muxes.
- The controller FSM, counters and mem all live in sort8_ctrl.

Test Plan:
- Sorted input 1,2,3,4,5,6,7,8 with out_ready=1:
  - SORT lasts exactly 7 cycles.
  - Output is 1..8.
  - done pulses once, one cycle after the 8th output handshake.
- Reverse input 8,7,6,5,4,3,2,1:
  - SORT lasts exactly 28 cycles.
  - Output is 1..8.
- Duplicates and extremes 0xFF,0x00,0x80,0x80,0x01,0xFF,0x00,0x7F:
  - Output is 00,00,01,7F,80,80,FF,FF.
  - No swap occurs on equal pairs.
- Backpressure: toggle out_ready randomly during OUT:
  - out_data stays stable while stalled.
  - All 8 bytes appear in order.
  - in_ready=0 throughout SORT and OUT.
- Assert rst_n=0 in the 10th SORT cycle of the reverse block:
  - All outputs drop to 0 asynchronously.
  - A subsequent block 3,1,2,0,7,5,6,4 sorts correctly to 0..7.
  - No stray done pulse.
- Two back-to-back blocks with in_valid held high:
  - The second block's first byte is accepted in the done cycle.
  - Both blocks output sorted.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared definitions for the byte-sort sequencer.
//   state_t : controller states (LOAD -> SORT -> OUT -> LOAD)
//   DATA_W  : byte width, tied to the single 8-bit comparator
//   N_DEF   : default block length
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int DATA_W = 8;
    localparam int N_DEF  = 8;

endpackage

// File: rtl/sort8_ctrl_cmp.sv
// Unsigned magnitude comparator, the only compare resource of the sorter.
//   a, b : unsigned operands
//   gte  : a >= b
module sort8_ctrl_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gte
);

    assign gte = (a >= b);

endmodule

// File: rtl/sort8_ctrl.sv
// Block bubble sorter: loads N bytes over valid/ready, sorts them in place
// with one compare per cycle on a shared comparator, then streams them out
// smallest first.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_data      : input byte stream
//   in_ready              : high while loading a block
//   out_valid/out_data    : sorted byte stream (out_data is 0 when idle)
//   out_ready             : consumer accept
//   busy                  : high in SORT or OUT
//   done                  : one-cycle pulse after the last output handshake
module sort8_ctrl
    import sort_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N);

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [CW-1:0] LAST_CMP = CW'(N - 2);

    state_t state, state_nx;

    logic [N-1:0][W-1:0] mem;
    logic [CW-1:0]       wr_idx, rd_idx, idx, pass;
    logic                swapped;
    logic                done_q;

    logic [W-1:0] cmp_a, cmp_b;
    logic         gte;
    logic         in_fire, out_fire;
    logic         in_last, out_last;
    logic         pass_end, sort_exit;

    // Comparator looks at the adjacent pair idx/idx+1; A is the upper slot,
    // so gte==0 means the pair is strictly out of order.
    assign cmp_a = mem[idx + CW'(1)];
    assign cmp_b = mem[idx];

    sort8_ctrl_cmp #(.W(W)) u_cmp (
        .a   (cmp_a),
        .b   (cmp_b),
        .gte (gte)
    );

    // in_ready is gated by rst_n so it reads 0 while reset is held even
    // though the state register already sits in LOAD.
    assign in_ready  = (state == LOAD) && rst_n;
    assign out_valid = (state == OUT);
    assign busy      = (state != LOAD);
    assign out_data  = out_valid ? mem[rd_idx] : '0;
    assign done      = done_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign in_last  = (wr_idx == LAST_IDX);
    assign out_last = (rd_idx == LAST_IDX);

    // Each pass shrinks by one since the largest remaining byte has bubbled
    // to the top. An early exit needs no swap anywhere in the pass, the
    // current cycle included.
    assign pass_end  = (idx >= LAST_CMP - pass);
    assign sort_exit = pass_end && ((pass == LAST_CMP) || !(swapped || !gte));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (in_fire && in_last)   state_nx = SORT;
            SORT:    if (sort_exit)            state_nx = OUT;
            OUT:     if (out_fire && out_last) state_nx = LOAD;
            default:                           state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem     <= '0;
            wr_idx  <= '0;
            rd_idx  <= '0;
            idx     <= '0;
            pass    <= '0;
            swapped <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= out_fire && out_last;
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        mem[wr_idx] <= in_data;
                        if (in_last) begin
                            wr_idx  <= '0;
                            idx     <= '0;
                            pass    <= '0;
                            swapped <= 1'b0;
                        end else begin
                            wr_idx <= wr_idx + CW'(1);
                        end
                    end
                end
                SORT: begin
                    // Strict order test keeps equal bytes in place (stable).
                    if (!gte) begin
                        mem[idx]          <= cmp_a;
                        mem[idx + CW'(1)] <= cmp_b;
                        swapped           <= 1'b1;
                    end
                    if (!pass_end) begin
                        idx <= idx + CW'(1);
                    end else if (sort_exit) begin
                        rd_idx <= '0;
                    end else begin
                        pass    <= pass + CW'(1);
                        idx     <= '0;
                        swapped <= 1'b0;
                    end
                end
                OUT: begin
                    if (out_fire) begin
                        rd_idx <= out_last ? '0 : rd_idx + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort8_ctrl.sv
module tb_sort8_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    sort8_ctrl #(.N(8), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [63:0] d;     // bytes in send order, first byte in the top bits
        logic [63:0] e;     // sorted bytes, same layout
        int          slen;  // expected SORT cycles, -1 = not checked
        bit          bp;    // random out_ready backpressure
    } vec_t;

    vec_t tbl [4];

    int checks   = 0;
    int failures = 0;
    bit bp       = 1'b0;

    logic [7:0] exp_q [$];
    int         slen_q [$];

    // Monitor state
    int         sort_cnt  = 0;
    int         out_cnt   = 0;
    bit         hs_last   = 1'b0;
    bit         stall     = 1'b0;
    logic [7:0] stall_dat = '0;
    int         s_exp;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Random backpressure is redrawn once per cycle, away from the edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output-side scoreboard and per-cycle protocol checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            sort_cnt = 0;
            out_cnt  = 0;
            hs_last  = 1'b0;
            stall    = 1'b0;
        end else begin
            check("done_pulse", done, hs_last);
            hs_last = 1'b0;
            if (busy) check("in_ready_busy", in_ready, 1'b0);
            if (!out_valid) check("out_data_idle", out_data, 8'h00);
            if (busy && !out_valid) sort_cnt++;
            if (out_valid && sort_cnt != 0) begin
                if (slen_q.size() == 0) begin
                    fail("sort_len_unexpected");
                end else begin
                    s_exp = slen_q.pop_front();
                    if (s_exp >= 0) check("sort_cycles", sort_cnt, s_exp);
                end
                sort_cnt = 0;
            end
            if (stall && out_valid) check("stall_hold", out_data, stall_dat);
            stall     = out_valid && !out_ready;
            stall_dat = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail("out_unexpected");
                else check("out_data", out_data, exp_q.pop_front());
                out_cnt++;
                if (out_cnt == 8) begin
                    hs_last = 1'b1;
                    out_cnt = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit chk_done);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) fail("in_ready_timeout");
        if (chk_done) check("b2b_done_on_accept", done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [63:0] e, input int slen);
        for (int i = 0; i < 8; i++) exp_q.push_back(e[63-8*i -: 8]);
        slen_q.push_back(slen);
    endtask

    task automatic send_block(input logic [63:0] d, input bit chk_first);
        for (int i = 0; i < 8; i++) send(d[63-8*i -: 8], chk_first && i == 0);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || busy) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{d: 64'h0102030405060708, e: 64'h0102030405060708, slen: 7,  bp: 1'b0};
        tbl[1] = '{d: 64'h0807060504030201, e: 64'h0102030405060708, slen: 28, bp: 1'b0};
        tbl[2] = '{d: 64'hFF00808001FF007F, e: 64'h0000017F8080FFFF, slen: 27, bp: 1'b0};
        tbl[3] = '{d: 64'h3C5A12F00E99A741, e: 64'h0E123C415A99A7F0, slen: -1, bp: 1'b1};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        check("rst_in_ready",  in_ready,  1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data,  8'h00);
        check("rst_busy",      busy,      1'b0);
        check("rst_done",      done,      1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1'b1);
        @(posedge clk);
        #1;

        for (int v = 0; v < 4; v++) begin
            bp = tbl[v].bp;
            push_exp(tbl[v].e, tbl[v].slen);
            send_block(tbl[v].d, 1'b0);
            in_valid = 1'b0;
            drain();
            bp = 1'b0;
        end

        // Abort a reverse block in its 10th SORT cycle.
        send_block(64'h0807060504030201, 1'b0);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_in_sort", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready",  in_ready,  1'b0);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_data",  out_data,  8'h00);
        check("abort_busy",      busy,      1'b0);
        check("abort_done",      done,      1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(64'h0001020304050607, -1);
        send_block(64'h0301020007050604, 1'b0);
        in_valid = 1'b0;
        drain();

        // Back-to-back blocks, in_valid never dropped.
        push_exp(64'h0010203040506070, -1);
        push_exp(64'h0102030607080909, -1);
        send_block(64'h1030204050607000, 1'b0);
        send_block(64'h0909010802070306, 1'b1);
        in_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
